// File: rtl/rs_wdec_pkg.sv
// ----------------------------------------------------------------------------
// rs_wdec_pkg
// Shared constants and types for the pipelined RS write decoder.
//   DEF_ADDR_W / DEF_DATA_W / DEF_NUM_CH / DEF_CNT_W : default widths
//   wr_req_t : {addr, data, bad} write request at the default widths
//   onehot() : address -> NUM_CH-bit one-hot strobe (all-zero out of range)
// ----------------------------------------------------------------------------
package rs_wdec_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 12;
    localparam int DEF_CNT_W  = 8;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
        logic                  bad;
    } wr_req_t;

    // Addresses beyond the channel count produce no strobe bit at all.
    function automatic logic [DEF_NUM_CH-1:0] onehot(input logic [DEF_ADDR_W-1:0] addr);
        logic [DEF_NUM_CH-1:0] result;
        result = '0;
        for (int i = 0; i < DEF_NUM_CH; i++) begin
            if (addr == DEF_ADDR_W'(i)) begin
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rs_write_decoder_pipe_dec.sv
// ----------------------------------------------------------------------------
// rs_onehot_dec
// Combinational address decoder sitting between the S1 and S2 registers.
// Ports:
//   addr     in  ADDR_W  channel address
//   strobe   out NUM_CH  one-hot strobe, all-zero when addr is out of range
//   in_range out 1       addr < NUM_CH
// ----------------------------------------------------------------------------
module rs_onehot_dec
    import rs_wdec_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NUM_CH-1:0] strobe,
    output logic              in_range
);

    // The range check falls out of the decode itself: an address with no
    // matching channel yields an empty strobe. This also covers the
    // NUM_CH == 2**ADDR_W case, where every address is legal.
    always_comb begin
        strobe = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(i)) begin
                strobe[i] = 1'b1;
            end
        end
        in_range = |strobe;
    end

endmodule

// File: rtl/rs_write_decoder_pipe.sv
// ----------------------------------------------------------------------------
// rs_write_decoder_pipe
// Two-stage pipelined RS write decoder. Write requests enter S1 on a
// valid/ready handshake, are decoded to a one-hot channel strobe and presented
// from the S2 output register on a back-pressurable valid/ready interface.
// Illegal writes are retired from S1 without touching S2 and are reported
// through sticky error flags and a saturating drop counter.
//
// Optional feature macro: RSDEC_PARITY_EN
//   defined   : even parity over {in_addr,in_data,in_parity} is checked at
//               acceptance; failing requests are dropped and set err_par.
//   undefined : in_parity is ignored and err_par is tied to 0.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake (in_ready is combinational)
//   in_addr, in_data       request channel address and write data
//   in_parity              even-parity bit (only with RSDEC_PARITY_EN)
//   out_valid/out_ready    decoded write handshake
//   out_strobe, out_data   one-hot channel strobe and write data
//   clr_err                synchronous clear of err_addr, err_par, drop_cnt
//   err_addr, err_par      sticky drop reasons
//   drop_cnt               saturating count of dropped requests
// ----------------------------------------------------------------------------
module rs_write_decoder_pipe
    import rs_wdec_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] out_strobe,
    output logic [DATA_W-1:0] out_data,
    input  logic              clr_err,
    output logic              err_addr,
    output logic              err_par,
    output logic [CNT_W-1:0]  drop_cnt
);

    // S1 entry at this instance's widths; same layout as the package wr_req_t.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bad;
    } req_t;

    logic              s1_valid;
    req_t              s1_req;
    logic [NUM_CH-1:0] s1_strobe;
    logic              s1_in_range;
    logic              in_par_fail;
    logic              in_fire;
    logic              s2_load;
    logic              s1_range_bad;
    logic              s1_par_bad;
    logic              s1_bad;
    logic              s1_adv;

`ifdef RSDEC_PARITY_EN
    // Even parity: the XOR over address, data and parity bit must be zero.
    assign in_par_fail = ^{in_addr, in_data, in_parity};
`else
    logic unused_parity;
    assign unused_parity = in_parity;
    assign in_par_fail   = 1'b0;
`endif

    rs_onehot_dec #(
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH)
    ) u_dec (
        .addr     (s1_req.addr),
        .strobe   (s1_strobe),
        .in_range (s1_in_range)
    );

    // A bad S1 entry always advances because it retires without needing S2.
    // This keeps a dropped request from ever blocking the input.
    always_comb begin
        s2_load      = !out_valid || out_ready;
        s1_range_bad = s1_valid && !s1_in_range;
        s1_par_bad   = s1_valid && s1_req.bad;
        s1_bad       = s1_range_bad || s1_par_bad;
        s1_adv       = s1_valid && (s1_bad || s2_load);
    end

    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // S1 holds a single entry. The parity verdict is captured alongside the
    // request because in_parity is only meaningful in the accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_fire) begin
            s1_valid    <= 1'b1;
            s1_req.addr <= in_addr;
            s1_req.data <= in_data;
            s1_req.bad  <= in_par_fail;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 output register. out_data is deliberately left holding the last
    // delivered value when the stage empties; only valid and strobe clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_strobe <= '0;
            out_data   <= '0;
        end else if (s1_adv && !s1_bad) begin
            out_valid  <= 1'b1;
            out_strobe <= s1_strobe;
            out_data   <= s1_req.data;
        end else if (s2_load) begin
            out_valid  <= 1'b0;
            out_strobe <= '0;
        end
    end

    // Error reporting. A drop in the same cycle as clr_err wins over the
    // clear, so the counter restarts at 1 rather than being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (s1_range_bad) begin
                err_addr <= 1'b1;
            end else if (clr_err) begin
                err_addr <= 1'b0;
            end

            if (s1_bad) begin
                if (clr_err) begin
                    drop_cnt <= CNT_W'(1);
                end else if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end else if (clr_err) begin
                drop_cnt <= '0;
            end
        end
    end

`ifdef RSDEC_PARITY_EN
    // Sticky parity error flag, same set-beats-clear rule as err_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_par <= 1'b0;
        end else if (s1_par_bad) begin
            err_par <= 1'b1;
        end else if (clr_err) begin
            err_par <= 1'b0;
        end
    end
`else
    assign err_par = 1'b0;
`endif

endmodule

// File: tb/tb_rs_write_decoder_pipe.sv
// ----------------------------------------------------------------------------
// tb_rs_write_decoder_pipe
// Self-checking bench for rs_write_decoder_pipe. A transaction-level model of
// the two-slot pipeline (input slot, output slot, error bookkeeping) predicts
// every output each cycle; directed sequences add literal expectations.
// ----------------------------------------------------------------------------
module tb_rs_write_decoder_pipe;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int NUM_CH = 12;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [ADDR_W-1:0] in_addr   = '0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_parity = 1'b0;
    logic              out_ready = 1'b0;
    logic              clr_err   = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [NUM_CH-1:0] out_strobe;
    logic [DATA_W-1:0] out_data;
    logic              err_addr;
    logic              err_par;
    logic [CNT_W-1:0]  drop_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int good_xfers  = 0;

    always #5 clk = ~clk;

    rs_write_decoder_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .clr_err    (clr_err),
        .err_addr   (err_addr),
        .err_par    (err_par),
        .drop_cnt   (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic rdy,
                                 input logic clr, input logic corrupt_par);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        in_parity = (^{a, d}) ^ corrupt_par;
        out_ready = rdy;
        clr_err   = clr;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Reference model: an input slot and an output slot. A request whose
    // address is out of range (or whose parity fails) is thrown away after
    // spending exactly one cycle in the input slot.
    // ------------------------------------------------------------------
    logic              m_in_occ;
    logic [ADDR_W-1:0] m_in_addr;
    logic [DATA_W-1:0] m_in_data;
    logic              m_in_pbad;
    logic              m_out_occ;
    logic [ADDR_W-1:0] m_out_addr;
    logic [DATA_W-1:0] m_out_data;
    logic              m_err_addr;
    logic              m_err_par;
    int                m_cnt;

    task automatic modelReset();
        m_in_occ   = 1'b0;
        m_in_addr  = '0;
        m_in_data  = '0;
        m_in_pbad  = 1'b0;
        m_out_occ  = 1'b0;
        m_out_addr = '0;
        m_out_data = '0;
        m_err_addr = 1'b0;
        m_err_par  = 1'b0;
        m_cnt      = 0;
    endtask

    task automatic modelStep();
        logic              range_bad;
        logic              drop;
        logic              exp_ready;
        logic              out_free;
        logic [NUM_CH-1:0] exp_strobe;

        if (!rst_n) begin
            modelReset();
        end

        range_bad  = m_in_occ && (int'(m_in_addr) >= NUM_CH);
        drop       = m_in_occ && (range_bad || m_in_pbad);
        out_free   = !m_out_occ || out_ready;
        exp_ready  = !m_in_occ || drop || out_free;
        exp_strobe = m_out_occ ? (12'd1 << m_out_addr) : 12'd0;

        checkOutput("in_ready",   32'(in_ready),   32'(exp_ready));
        checkOutput("out_valid",  32'(out_valid),  32'(m_out_occ));
        checkOutput("out_strobe", 32'(out_strobe), 32'(exp_strobe));
        checkOutput("out_data",   32'(out_data),   32'(m_out_data));
        checkOutput("err_addr",   32'(err_addr),   32'(m_err_addr));
        checkOutput("err_par",    32'(err_par),    32'(m_err_par));
        checkOutput("drop_cnt",   32'(drop_cnt),   32'(m_cnt));

        if (rst_n) begin
            if (m_out_occ && out_ready) begin
                good_xfers++;
            end

            if (clr_err) begin
                m_err_addr = 1'b0;
                m_err_par  = 1'b0;
                m_cnt      = 0;
            end
            if (range_bad) begin
                m_err_addr = 1'b1;
            end
            if (m_in_occ && m_in_pbad) begin
                m_err_par = 1'b1;
            end
            if (drop && m_cnt < CNT_MAX) begin
                m_cnt++;
            end

            if (m_in_occ && !drop && out_free) begin
                m_out_occ  = 1'b1;
                m_out_addr = m_in_addr;
                m_out_data = m_in_data;
                m_in_occ   = 1'b0;
            end else if (out_free) begin
                m_out_occ = 1'b0;
            end
            if (drop) begin
                m_in_occ = 1'b0;
            end

            if (in_valid && exp_ready) begin
                m_in_occ  = 1'b1;
                m_in_addr = in_addr;
                m_in_data = in_data;
`ifdef RSDEC_PARITY_EN
                m_in_pbad = ^{in_addr, in_data, in_parity};
`else
                m_in_pbad = 1'b0;
`endif
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            modelStep();
        end
    end

    // ------------------------------------------------------------------
    // Directed sequences with literal expectations, then random traffic.
    // ------------------------------------------------------------------
    initial begin
        int base;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset drop_cnt",  32'(drop_cnt),  32'd0);

        // Single write addr 3, data A5
        applyStimulus(1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        checkOutput("t1 out_valid",  32'(out_valid),  32'd1);
        checkOutput("t1 out_strobe", 32'(out_strobe), 32'h008);
        checkOutput("t1 out_data",   32'(out_data),   32'hA5);
        repeat (2) idle(1'b1);

        // Back-to-back stream of every legal channel
        base = good_xfers;
        for (int i = 0; i < NUM_CH; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), DATA_W'(8'h40 + i), 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("t2 in_ready", 32'(in_ready), 32'd1);
        end
        repeat (4) idle(1'b1);
        checkOutput("t2 transfers", 32'(good_xfers - base), 32'd12);

        // Back-pressure with two requests pending
        applyStimulus(1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd6, 8'h22, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        checkOutput("t3 in_ready stall", 32'(in_ready),   32'd0);
        checkOutput("t3 held strobe",    32'(out_strobe), 32'h020);
        idle(1'b0);
        @(negedge clk);
        checkOutput("t3 still held",     32'(out_data),   32'h11);
        base = good_xfers;
        repeat (4) idle(1'b1);
        checkOutput("t3 released", 32'(good_xfers - base), 32'd2);

        // Out-of-range writes between legal ones
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd2,  8'h33, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd12, 8'h44, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd15, 8'h55, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd11, 8'h66, 1'b1, 1'b0, 1'b0);
        repeat (3) idle(1'b1);
        @(negedge clk);
        checkOutput("t4 err_addr", 32'(err_addr), 32'd1);
        checkOutput("t4 drop_cnt", 32'(drop_cnt), 32'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk);
        checkOutput("t4 cleared flag", 32'(err_addr), 32'd0);
        checkOutput("t4 cleared cnt",  32'(drop_cnt), 32'd0);

        // clr_err coinciding with a drop: the drop wins
        applyStimulus(1'b1, 4'd12, 8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd12, 8'h02, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd13, 8'h03, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk);
        checkOutput("clr+drop cnt",  32'(drop_cnt), 32'd1);
        checkOutput("clr+drop flag", 32'(err_addr), 32'd1);

        // Saturation of the drop counter
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            applyStimulus(1'b1, 4'd14, DATA_W'(i), 1'b1, 1'b0, 1'b0);
        end
        repeat (2) idle(1'b1);
        @(negedge clk);
        checkOutput("t5 saturated", 32'(drop_cnt), 32'd255);

        // Asynchronous reset in the middle of a stream
        applyStimulus(1'b1, 4'd7, 8'h77, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd8, 8'h88, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 8'h99, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_valid",  32'(out_valid),  32'd0);
        checkOutput("rst out_strobe", 32'(out_strobe), 32'd0);
        checkOutput("rst out_data",   32'(out_data),   32'd0);
        checkOutput("rst drop_cnt",   32'(drop_cnt),   32'd0);
        checkOutput("rst err_addr",   32'(err_addr),   32'd0);
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b1;
        repeat (2) idle(1'b1);
        @(negedge clk);
        checkOutput("post-rst out_valid", 32'(out_valid), 32'd0);

`ifdef RSDEC_PARITY_EN
        // Parity failure and the same request with good parity
        applyStimulus(1'b1, 4'd1, 8'h01, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        checkOutput("t6 err_par",    32'(err_par),   32'd1);
        checkOutput("t6 no output",  32'(out_valid), 32'd0);
        applyStimulus(1'b1, 4'd1, 8'h01, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        checkOutput("t6 strobe", 32'(out_strobe), 32'h002);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) != 0,
                          ADDR_W'($urandom % 16),
                          DATA_W'($urandom),
                          ($urandom % 3) != 0,
                          ($urandom % 50) == 0,
                          ($urandom % 8) == 0);
        end
        repeat (5) idle(1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
